uart2apb_bridge_p: RTL

- Parametrised second-generation UART-to-APB master bridge. Takes framed command packets on a UART RX line and turns each one into a single APB write or read.
- Returns a status byte on UART TX for every accepted packet; read data follows the status byte.
- Address/data width, baud divisor, parity mode and timeouts are configurable.
- Adds features the first-generation bridge lacks: inter-byte gap timeout, APB timeout, PSLVERR reporting, framing/parity error reporting and write acknowledge.

---
 rtl/uart2apb_bridge_p.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart2apb_bridge_p.sv
// UART-framed command packets in, one APB write/read per packet, status (+read data) back out on TX.
// Receiver free-runs; packets are accepted only in IDLE; every accepted packet gets exactly one status byte.
module uart2apb_bridge_p #(
  parameter int          ADDR_BYTES   = 2,
  parameter int          DATA_BYTES   = 4,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          PARITY_EN    = 1,
  parameter int          PARITY_ODD   = 1,
  parameter int          GAP_BITS     = 20,
  parameter int          APB_TIMEOUT  = 255,
  parameter logic [7:0]  CMD_WR       = 8'hA5,
  parameter logic [7:0]  CMD_RD       = 8'h5A
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic                      tx,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [8*ADDR_BYTES-1:0]   paddr,
  output logic [8*DATA_BYTES-1:0]   pwdata,
  input  logic                      pready,
  input  logic [8*DATA_BYTES-1:0]   prdata,
  input  logic                      pslverr,
  output logic                      busy
);

  localparam int   AW       = 8 * ADDR_BYTES;
  localparam int   DW       = 8 * DATA_BYTES;
  localparam int   CW       = $clog2(CLKS_PER_BIT);
  localparam int   HALF     = CLKS_PER_BIT / 2;
  localparam int   STOP_IDX = (PARITY_EN != 0) ? 10 : 9;
  localparam int   GAP_LIM  = GAP_BITS * CLKS_PER_BIT;
  localparam int   GW       = $clog2(GAP_LIM + 1);
  localparam int   TW       = $clog2(APB_TIMEOUT + 1);
  localparam int   BW       = $clog2(ADDR_BYTES + DATA_BYTES + 1);
  localparam logic PODD     = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, APB_SETUP, APB_ACCESS, TX_STATUS, TX_DATA
  } state_t;

  // Bits following the start bit, LSB shifted out first.
  function automatic logic [9:0] tx_frame(input logic [7:0] b);
    tx_frame = {1'b1, (PARITY_EN != 0) ? ((^b) ^ PODD) : 1'b1, b};
  endfunction

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic          rx_act_q, rx_par_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          byte_vld_q, byte_err_q;
  logic [7:0]    byte_dat_q;

  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          gap_to;

  state_t        state_q;
  logic          tx_q, psel_q, penable_q, pwrite_q, busy_q, cmd_rd_q;
  logic [AW-1:0] paddr_q;
  logic [DW-1:0] pwdata_q, rdata_q;
  logic [7:0]    status_q;
  logic [BW-1:0] byte_cnt_q;
  logic [TW-1:0] apb_cnt_q;
  logic [9:0]    tx_sh_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;

  logic [7:0]    err_status, apb_status;
  logic          tx_more;

  assign tx      = tx_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign busy    = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_act_q   <= 1'b0;
      rx_par_q   <= 1'b0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      byte_vld_q <= 1'b0;
      byte_err_q <= 1'b0;
      byte_dat_q <= '0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      byte_vld_q <= 1'b0;
      if (!rx_act_q) begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_act_q <= 1'b1;
          rx_cnt_q <= CW'(1);
          rx_bit_q <= '0;
          rx_par_q <= 1'b0;
        end
      end else begin
        if (rx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          rx_cnt_q <= '0;
          rx_bit_q <= rx_bit_q + 4'd1;
        end else begin
          rx_cnt_q <= rx_cnt_q + CW'(1);
        end
        if (rx_cnt_q == CW'(HALF)) begin
          if (rx_bit_q == 4'd0) begin
            if (rx_s2_q) rx_act_q <= 1'b0;
          end else if (rx_bit_q <= 4'd8) begin
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_par_q <= rx_par_q ^ rx_s2_q;
          end else if (rx_bit_q == 4'(STOP_IDX)) begin
            byte_vld_q <= 1'b1;
            byte_dat_q <= rx_sh_q;
            byte_err_q <= !rx_s2_q || ((PARITY_EN != 0) && (rx_par_q != PODD));
            rx_act_q   <= 1'b0;
          end else begin
            rx_par_q <= rx_par_q ^ rx_s2_q;
          end
        end
      end
    end
  end

  // Gap timer only runs between bytes of a packet; an in-flight byte holds it at zero.
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (byte_vld_q || rx_act_q || !(state_q == ADDR || state_q == WDATA))
      gap_cnt_d = '0;
    else if (!gap_to)
      gap_cnt_d = gap_cnt_q + GW'(1);
  end

  assign gap_to = (gap_cnt_q == GW'(GAP_LIM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gap_cnt_q <= '0;
    else     gap_cnt_q <= gap_cnt_d;
  end

  always_comb begin
    err_status = byte_vld_q ? 8'h03 : 8'h04;
    apb_status = !pready ? 8'h02 : (pslverr ? 8'h01 : 8'h00);
    tx_more    = (state_q == TX_STATUS) ? (cmd_rd_q && status_q == 8'h00)
                                        : (byte_cnt_q != BW'(DATA_BYTES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      busy_q     <= 1'b0;
      cmd_rd_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      rdata_q    <= '0;
      status_q   <= '0;
      byte_cnt_q <= '0;
      apb_cnt_q  <= '0;
      tx_sh_q    <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (byte_vld_q && !byte_err_q && (byte_dat_q == CMD_WR || byte_dat_q == CMD_RD)) begin
            cmd_rd_q   <= (byte_dat_q == CMD_RD);
            byte_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ADDR;
          end
        end
        ADDR, WDATA: begin
          if ((byte_vld_q && byte_err_q) || (!byte_vld_q && gap_to)) begin
            status_q <= err_status;
            tx_q     <= 1'b0;
            tx_sh_q  <= tx_frame(err_status);
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            state_q  <= TX_STATUS;
          end else if (byte_vld_q) begin
            if (state_q == ADDR) begin
              paddr_q <= (paddr_q >> 8) | (AW'(byte_dat_q) << (AW - 8));
              if (byte_cnt_q == BW'(ADDR_BYTES - 1)) begin
                byte_cnt_q <= '0;
                if (cmd_rd_q) begin
                  psel_q   <= 1'b1;
                  pwrite_q <= 1'b0;
                  state_q  <= APB_SETUP;
                end else begin
                  state_q  <= WDATA;
                end
              end else begin
                byte_cnt_q <= byte_cnt_q + BW'(1);
              end
            end else begin
              pwdata_q <= (pwdata_q >> 8) | (DW'(byte_dat_q) << (DW - 8));
              if (byte_cnt_q == BW'(DATA_BYTES - 1)) begin
                byte_cnt_q <= '0;
                psel_q     <= 1'b1;
                pwrite_q   <= 1'b1;
                state_q    <= APB_SETUP;
              end else begin
                byte_cnt_q <= byte_cnt_q + BW'(1);
              end
            end
          end
        end
        APB_SETUP: begin
          penable_q <= 1'b1;
          apb_cnt_q <= '0;
          state_q   <= APB_ACCESS;
        end
        APB_ACCESS: begin
          if (pready || apb_cnt_q == TW'(APB_TIMEOUT - 1)) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            if (pready && cmd_rd_q) rdata_q <= prdata;
            status_q  <= apb_status;
            tx_q      <= 1'b0;
            tx_sh_q   <= tx_frame(apb_status);
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            state_q   <= TX_STATUS;
          end else begin
            apb_cnt_q <= apb_cnt_q + TW'(1);
          end
        end
        TX_STATUS, TX_DATA: begin
          if (tx_cnt_q != CW'(CLKS_PER_BIT - 1)) begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end else begin
            tx_cnt_q <= '0;
            if (tx_bit_q != 4'(STOP_IDX)) begin
              tx_q     <= tx_sh_q[0];
              tx_sh_q  <= tx_sh_q >> 1;
              tx_bit_q <= tx_bit_q + 4'd1;
            end else if (tx_more) begin
              // Next byte's start bit follows the stop bit with no idle gap.
              tx_q       <= 1'b0;
              tx_sh_q    <= tx_frame(rdata_q[7:0]);
              rdata_q    <= rdata_q >> 8;
              tx_bit_q   <= '0;
              byte_cnt_q <= (state_q == TX_DATA) ? byte_cnt_q + BW'(1) : '0;
              state_q    <= TX_DATA;
            end else begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
